// File: rtl/hdmi_char_pkg.sv
// hdmi_char_pkg: SVGA timing defaults, TMDS control tokens and the "HELLO" font ROM
// shared by the hdmi_char_tx video path.
package hdmi_char_pkg;

  localparam int unsigned H_ACT  = 800;
  localparam int unsigned H_FP   = 40;
  localparam int unsigned H_SYNC = 128;
  localparam int unsigned H_BP   = 88;
  localparam int unsigned H_TOT  = H_ACT + H_FP + H_SYNC + H_BP;

  // Vertical timing and text origin are defaults; the top exposes them as parameters.
  localparam int unsigned DEF_V_ACT  = 600;
  localparam int unsigned DEF_V_FP   = 1;
  localparam int unsigned DEF_V_SYNC = 4;
  localparam int unsigned DEF_V_BP   = 23;
  localparam int unsigned DEF_TXT_X  = 336;
  localparam int unsigned DEF_TXT_Y  = 284;

  localparam int unsigned SCALE    = 4;
  localparam int unsigned SCALE_SH = $clog2(SCALE);
  localparam int unsigned GLYPHS   = 5;
  localparam int unsigned BOX_W    = GLYPHS * 8 * SCALE;
  localparam int unsigned BOX_H    = 8 * SCALE;
  localparam int unsigned RST_HOLD = 16;

  localparam logic [9:0] CLK_WORD = 10'b1111100000;
  localparam logic [9:0] CTRL_00  = 10'b1101010100;
  localparam logic [9:0] CTRL_01  = 10'b0010101011;
  localparam logic [9:0] CTRL_10  = 10'b0101010100;
  localparam logic [9:0] CTRL_11  = 10'b1010101011;

  localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;
  localparam logic [23:0] RGB_BLUE  = 24'h0000FF;

  // Glyph rows, MSB is the leftmost pixel: H, E, L, L, O.
  localparam logic [7:0] FONT [0:39] = '{
    8'h66, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h66, 8'h00,
    8'h7E, 8'h60, 8'h60, 8'h7C, 8'h60, 8'h60, 8'h7E, 8'h00,
    8'h60, 8'h60, 8'h60, 8'h60, 8'h60, 8'h60, 8'h7E, 8'h00,
    8'h60, 8'h60, 8'h60, 8'h60, 8'h60, 8'h60, 8'h7E, 8'h00,
    8'h3C, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00
  };

  function automatic logic [7:0] font_row(input logic [2:0] glyph, input logic [2:0] row);
    logic [5:0] idx;
    idx = {glyph, row};
    if (glyph < 3'd5) begin
      return FONT[idx];
    end else begin
      return 8'h00;
    end
  endfunction

  function automatic logic [9:0] ctrl_token(input logic c1, input logic c0);
    case ({c1, c0})
      2'b00:   return CTRL_00;
      2'b01:   return CTRL_01;
      2'b10:   return CTRL_10;
      2'b11:   return CTRL_11;
      default: return CTRL_00;
    endcase
  endfunction

endpackage

// File: rtl/hdmi_char_tx_tmds_encoder.sv
// tmds_encoder: registered DVI 1.0 TMDS encoder (transition minimising, DC balancing,
// control tokens during blanking) for one data lane.
module tmds_encoder
  import hdmi_char_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       de,
  input  logic       c0,
  input  logic       c1,
  input  logic [7:0] d,
  output logic [9:0] q
);

  logic [9:0]        q_r;
  logic [9:0]        q_next_s;
  logic signed [5:0] cnt_r;
  logic signed [5:0] cnt_next_s;
  logic [3:0]        n1d_s;
  logic [3:0]        n1q_s;
  logic [3:0]        n0q_s;
  logic [8:0]        qm_s;
  logic              xnor_sel_s;
  logic signed [5:0] bal_s;

  // Transition-minimised intermediate word and its ones/zeros balance.
  always_comb begin
    n1d_s = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n1d_s = n1d_s + {3'd0, d[i]};
    end
    xnor_sel_s = (n1d_s > 4'd4) || ((n1d_s == 4'd4) && (d[0] == 1'b0));
    qm_s[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      if (xnor_sel_s) begin
        qm_s[i] = ~(qm_s[i-1] ^ d[i]);
      end else begin
        qm_s[i] = qm_s[i-1] ^ d[i];
      end
    end
    qm_s[8] = ~xnor_sel_s;
    n1q_s = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n1q_s = n1q_s + {3'd0, qm_s[i]};
    end
    n0q_s = 4'd8 - n1q_s;
    bal_s = $signed({2'b00, n1q_s}) - $signed({2'b00, n0q_s});
  end

  // Output word selection; cnt tracks ones-minus-zeros of words sent since blanking.
  always_comb begin
    q_next_s   = CTRL_00;
    cnt_next_s = 6'sd0;
    if (!de) begin
      q_next_s   = ctrl_token(c1, c0);
      cnt_next_s = 6'sd0;
    end else if ((cnt_r == 6'sd0) || (n1q_s == n0q_s)) begin
      q_next_s = {~qm_s[8], qm_s[8], (qm_s[8] ? qm_s[7:0] : ~qm_s[7:0])};
      if (qm_s[8]) begin
        cnt_next_s = cnt_r + bal_s;
      end else begin
        cnt_next_s = cnt_r - bal_s;
      end
    end else if (((cnt_r > 6'sd0) && (n1q_s > n0q_s)) || ((cnt_r < 6'sd0) && (n0q_s > n1q_s))) begin
      q_next_s   = {1'b1, qm_s[8], ~qm_s[7:0]};
      cnt_next_s = cnt_r + $signed({4'd0, qm_s[8], 1'b0}) - bal_s;
    end else begin
      q_next_s   = {1'b0, qm_s[8], qm_s[7:0]};
      cnt_next_s = cnt_r - $signed({4'd0, ~qm_s[8], 1'b0}) + bal_s;
    end
  end

  // Encoder output and disparity registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r   <= CTRL_00;
      cnt_r <= 6'sd0;
    end else begin
      q_r   <= q_next_s;
      cnt_r <= cnt_next_s;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/hdmi_char_tx.sv
// hdmi_char_tx: 800x600@60 DVI source rendering "HELLO" on a blue field.
// Optional macro HDMI_TEST_BARS_EN replaces the background with eight 100-px colour bars.
module hdmi_char_tx
  import hdmi_char_pkg::*;
#(
  parameter int unsigned V_ACT  = DEF_V_ACT,
  parameter int unsigned V_FP   = DEF_V_FP,
  parameter int unsigned V_SYNC = DEF_V_SYNC,
  parameter int unsigned V_BP   = DEF_V_BP,
  parameter int unsigned TXT_X  = DEF_TXT_X,
  parameter int unsigned TXT_Y  = DEF_TXT_Y
) (
  input  logic       hdmi_clk,
  input  logic       hdmi_pll_LOCKED,
  output logic       tmds_clk_TX_OE,
  output logic [9:0] tmds_clk_TX_DATA,
  output logic       tmds_clk_TX_RST,
  output logic       tmds_data0_TX_OE,
  output logic [9:0] tmds_data0_TX_DATA,
  output logic       tmds_data0_TX_RST,
  output logic       tmds_data1_TX_OE,
  output logic [9:0] tmds_data1_TX_DATA,
  output logic       tmds_data1_TX_RST,
  output logic       tmds_data2_TX_OE,
  output logic [9:0] tmds_data2_TX_DATA,
  output logic       tmds_data2_TX_RST,
  output logic       hpd
);

  localparam int unsigned V_TOT    = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int unsigned GLYPH_SH = SCALE_SH + 3;

  localparam logic [10:0] H_LAST  = 11'(H_TOT - 1);
  localparam logic [10:0] H_ACT_W = 11'(H_ACT);
  localparam logic [10:0] HS_BEG  = 11'(H_ACT + H_FP);
  localparam logic [10:0] HS_END  = 11'(H_ACT + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST  = 10'(V_TOT - 1);
  localparam logic [9:0]  V_ACT_W = 10'(V_ACT);
  localparam logic [9:0]  VS_BEG  = 10'(V_ACT + V_FP);
  localparam logic [9:0]  VS_END  = 10'(V_ACT + V_FP + V_SYNC);
  localparam logic [10:0] BOX_X0  = 11'(TXT_X);
  localparam logic [10:0] BOX_W_W = 11'(BOX_W);
  localparam logic [9:0]  BOX_Y0  = 10'(TXT_Y);
  localparam logic [9:0]  BOX_H_W = 10'(BOX_H);
  localparam logic [4:0]  RST_LAST = 5'(RST_HOLD - 1);

  logic        rst_n;
  logic [10:0] hcnt_r;
  logic [9:0]  vcnt_r;
  logic        tx_oe_r;
  logic        tx_rst_r;
  logic [4:0]  rst_cnt_r;

  logic        de_s, hs_s, vs_s, in_box_s, pix_on_s;
  logic [10:0] dx_s;
  logic [9:0]  dy_s;
  logic [2:0]  glyph_s, row_s, col_s;
  logic [7:0]  font_bits_s;
  logic [23:0] bg_s, rgb_s;

  logic        de_r, hs_r, vs_r;
  logic [23:0] rgb_r;

  assign rst_n = hdmi_pll_LOCKED;

  // Serializer enable and reset hold after PLL lock.
  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_oe_r   <= 1'b0;
      tx_rst_r  <= 1'b1;
      rst_cnt_r <= 5'd0;
    end else begin
      tx_oe_r <= 1'b1;
      if (rst_cnt_r < RST_LAST) begin
        rst_cnt_r <= rst_cnt_r + 5'd1;
        tx_rst_r  <= 1'b1;
      end else begin
        rst_cnt_r <= rst_cnt_r;
        tx_rst_r  <= 1'b0;
      end
    end
  end

  // Stage 1: raster counters.
  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_r <= 11'd0;
      vcnt_r <= 10'd0;
    end else if (hcnt_r == H_LAST) begin
      hcnt_r <= 11'd0;
      vcnt_r <= (vcnt_r == V_LAST) ? 10'd0 : vcnt_r + 10'd1;
    end else begin
      hcnt_r <= hcnt_r + 11'd1;
      vcnt_r <= vcnt_r;
    end
  end

  // Sync/enable decode and text lookup from the current counter state.
  always_comb begin
    de_s     = (hcnt_r < H_ACT_W) && (vcnt_r < V_ACT_W);
    hs_s     = (hcnt_r >= HS_BEG) && (hcnt_r < HS_END);
    vs_s     = (vcnt_r >= VS_BEG) && (vcnt_r < VS_END);
    dx_s     = hcnt_r - BOX_X0;
    dy_s     = vcnt_r - BOX_Y0;
    in_box_s = (hcnt_r >= BOX_X0) && (dx_s < BOX_W_W) && (vcnt_r >= BOX_Y0) && (dy_s < BOX_H_W);
    glyph_s  = dx_s[GLYPH_SH +: 3];
    col_s    = dx_s[SCALE_SH +: 3];
    row_s    = dy_s[SCALE_SH +: 3];
    font_bits_s = font_row(glyph_s, row_s);
    pix_on_s = in_box_s && font_bits_s[3'd7 - col_s];
  end

  // Background colour behind the text.
  always_comb begin
    bg_s = RGB_BLUE;
`ifdef HDMI_TEST_BARS_EN
    if (hcnt_r < 11'd100) begin
      bg_s = 24'hFFFFFF;
    end else if (hcnt_r < 11'd200) begin
      bg_s = 24'hFFFF00;
    end else if (hcnt_r < 11'd300) begin
      bg_s = 24'h00FFFF;
    end else if (hcnt_r < 11'd400) begin
      bg_s = 24'h00FF00;
    end else if (hcnt_r < 11'd500) begin
      bg_s = 24'hFF00FF;
    end else if (hcnt_r < 11'd600) begin
      bg_s = 24'hFF0000;
    end else if (hcnt_r < 11'd700) begin
      bg_s = 24'h0000FF;
    end else begin
      bg_s = 24'h000000;
    end
`else
    bg_s = RGB_BLUE;
`endif
    rgb_s = pix_on_s ? RGB_WHITE : bg_s;
  end

  // Stage 2: pixel colour and control signals.
  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n) begin
      de_r  <= 1'b0;
      hs_r  <= 1'b0;
      vs_r  <= 1'b0;
      rgb_r <= 24'h000000;
    end else begin
      de_r  <= de_s;
      hs_r  <= hs_s;
      vs_r  <= vs_s;
      rgb_r <= rgb_s;
    end
  end

  // Stage 3: one encoder per colour lane; syncs ride on the blue lane.
  tmds_encoder u_enc_b (
    .clk(hdmi_clk), .rst_n(rst_n), .de(de_r), .c0(hs_r), .c1(vs_r),
    .d(rgb_r[7:0]), .q(tmds_data0_TX_DATA)
  );
  tmds_encoder u_enc_g (
    .clk(hdmi_clk), .rst_n(rst_n), .de(de_r), .c0(1'b0), .c1(1'b0),
    .d(rgb_r[15:8]), .q(tmds_data1_TX_DATA)
  );
  tmds_encoder u_enc_r (
    .clk(hdmi_clk), .rst_n(rst_n), .de(de_r), .c0(1'b0), .c1(1'b0),
    .d(rgb_r[23:16]), .q(tmds_data2_TX_DATA)
  );

  assign tmds_clk_TX_DATA  = CLK_WORD;
  assign tmds_clk_TX_OE    = tx_oe_r;
  assign tmds_clk_TX_RST   = tx_rst_r;
  assign tmds_data0_TX_OE  = tx_oe_r;
  assign tmds_data0_TX_RST = tx_rst_r;
  assign tmds_data1_TX_OE  = tx_oe_r;
  assign tmds_data1_TX_RST = tx_rst_r;
  assign tmds_data2_TX_OE  = tx_oe_r;
  assign tmds_data2_TX_RST = tx_rst_r;
  assign hpd               = 1'b1;

endmodule

// File: tb/tb_hdmi_char_tx.sv
// tb_hdmi_char_tx: scoreboard bench for hdmi_char_tx with a shortened vertical frame so a
// whole frame, the text box and vsync fit in a short run; TMDS words are decoded and compared.
module tb_hdmi_char_tx;

  localparam int H_TOT  = 1056;
  localparam int V_ACT  = 36;
  localparam int V_FP   = 1;
  localparam int V_SYNC = 4;
  localparam int V_BP   = 2;
  localparam int V_TOT  = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int TXT_X  = 336;
  localparam int TXT_Y  = 4;

  logic       hdmi_clk = 1'b0;
  logic       locked   = 1'b0;
  logic       clk_oe, clk_rst, d0_oe, d0_rst, d1_oe, d1_rst, d2_oe, d2_rst, hpd;
  logic [9:0] clk_word, d0_word, d1_word, d2_word;

  always #10 hdmi_clk = ~hdmi_clk;

  hdmi_char_tx #(
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .TXT_X(TXT_X), .TXT_Y(TXT_Y)
  ) dut (
    .hdmi_clk(hdmi_clk), .hdmi_pll_LOCKED(locked),
    .tmds_clk_TX_OE(clk_oe), .tmds_clk_TX_DATA(clk_word), .tmds_clk_TX_RST(clk_rst),
    .tmds_data0_TX_OE(d0_oe), .tmds_data0_TX_DATA(d0_word), .tmds_data0_TX_RST(d0_rst),
    .tmds_data1_TX_OE(d1_oe), .tmds_data1_TX_DATA(d1_word), .tmds_data1_TX_RST(d1_rst),
    .tmds_data2_TX_OE(d2_oe), .tmds_data2_TX_DATA(d2_word), .tmds_data2_TX_RST(d2_rst),
    .hpd(hpd)
  );

  typedef struct {
    logic        oe;
    logic        rst;
    logic        de;
    logic [9:0]  tok0;
    logic [23:0] rgb;
    int          h;
    int          v;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_edge   = 0;
  int   n_pops   = 0;
  bit   running  = 1'b0;
  int   disp[3];

  logic [7:0] font [5][8] = '{
    '{8'h66, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h66, 8'h00},
    '{8'h7E, 8'h60, 8'h60, 8'h7C, 8'h60, 8'h60, 8'h7E, 8'h00},
    '{8'h60, 8'h60, 8'h60, 8'h60, 8'h60, 8'h60, 8'h7E, 8'h00},
    '{8'h60, 8'h60, 8'h60, 8'h60, 8'h60, 8'h60, 8'h7E, 8'h00},
    '{8'h3C, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00}
  };
`ifdef HDMI_TEST_BARS_EN
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                           24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp,
                       input int h, input int v);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 20)
        $display("FAIL %s (h=%0d v=%0d): got %0h expected %0h", name, h, v, act, exp);
    end
  endtask

  function automatic logic [9:0] token(input logic vs, input logic hs);
    case ({vs, hs})
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  function automatic logic [23:0] pixel(input int h, input int v);
    logic [23:0] bg;
    logic [7:0]  row;
    int g, r, c;
    bg = 24'h0000FF;
`ifdef HDMI_TEST_BARS_EN
    bg = bars[h / 100];
`endif
    if (h >= TXT_X && h < TXT_X + 160 && v >= TXT_Y && v < TXT_Y + 32) begin
      g = (h - TXT_X) / 32;
      r = ((v - TXT_Y) / 4) % 8;
      c = ((h - TXT_X) / 4) % 8;
      row = font[g][r];
      if (row[7 - c]) return 24'hFFFFFF;
    end
    return bg;
  endfunction

  // Expected output after the n-th clock edge following reset release.
  function automatic exp_t model(input int n);
    exp_t e;
    int s;
    logic hs, vs;
    e.oe  = 1'b1;
    e.rst = (n < 16);
    if (n < 2) begin
      e.h = -1; e.v = -1; e.de = 1'b0; hs = 1'b0; vs = 1'b0; e.rgb = 24'h0;
    end else begin
      s = n - 2;
      e.h = s % H_TOT;
      e.v = (s / H_TOT) % V_TOT;
      e.de = (e.h < 800) && (e.v < V_ACT);
      hs = (e.h >= 840) && (e.h < 968);
      vs = (e.v >= V_ACT + 1) && (e.v < V_ACT + 5);
      e.rgb = pixel(e.h, e.v);
    end
    e.tok0 = token(vs, hs);
    return e;
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] w);
    logic [7:0] t, o;
    t = w[9] ? ~w[7:0] : w[7:0];
    o[0] = t[0];
    for (int i = 1; i < 8; i++) o[i] = w[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    return o;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_oe"},   {28'd0, clk_oe, d0_oe, d1_oe, d2_oe}, 32'h0, -1, -1);
    check({tag, "_rst"},  {28'd0, clk_rst, d0_rst, d1_rst, d2_rst}, 32'hF, -1, -1);
    check({tag, "_d0"},   {22'd0, d0_word}, {22'd0, 10'b1101010100}, -1, -1);
    check({tag, "_d1"},   {22'd0, d1_word}, {22'd0, 10'b1101010100}, -1, -1);
    check({tag, "_d2"},   {22'd0, d2_word}, {22'd0, 10'b1101010100}, -1, -1);
    check({tag, "_clk"},  {22'd0, clk_word}, {22'd0, 10'b1111100000}, -1, -1);
  endtask

  // Producer: one expected record per active clock edge.
  always @(posedge hdmi_clk) begin
    if (running) begin
      n_edge++;
      sb.push_back(model(n_edge));
    end
  end

  // Monitor: pops and compares on the falling edge.
  always @(negedge hdmi_clk) begin
    if (running && sb.size() > 0) begin
      int w1;
      mon_e = sb.pop_front();
      n_pops++;
      check("oe",  {28'd0, clk_oe, d0_oe, d1_oe, d2_oe}, {28'd0, {4{mon_e.oe}}}, mon_e.h, mon_e.v);
      check("rst", {28'd0, clk_rst, d0_rst, d1_rst, d2_rst}, {28'd0, {4{mon_e.rst}}}, mon_e.h, mon_e.v);
      check("clk_word", {22'd0, clk_word}, {22'd0, 10'b1111100000}, mon_e.h, mon_e.v);
      check("hpd", {31'd0, hpd}, 32'd1, mon_e.h, mon_e.v);
      if (mon_e.de) begin
        check("blue",  {24'd0, decode(d0_word)}, {24'd0, mon_e.rgb[7:0]},   mon_e.h, mon_e.v);
        check("green", {24'd0, decode(d1_word)}, {24'd0, mon_e.rgb[15:8]},  mon_e.h, mon_e.v);
        check("red",   {24'd0, decode(d2_word)}, {24'd0, mon_e.rgb[23:16]}, mon_e.h, mon_e.v);
        disp[0] += 2 * $countones(d0_word) - 10;
        disp[1] += 2 * $countones(d1_word) - 10;
        disp[2] += 2 * $countones(d2_word) - 10;
        w1 = 0;
        for (int l = 0; l < 3; l++) if (disp[l] > 10 || disp[l] < -10) w1 = 1;
        check("disparity", w1, 0, mon_e.h, mon_e.v);
      end else begin
        for (int l = 0; l < 3; l++) disp[l] = 0;
        check("tok0", {22'd0, d0_word}, {22'd0, mon_e.tok0}, mon_e.h, mon_e.v);
        check("tok1", {22'd0, d1_word}, {22'd0, 10'b1101010100}, mon_e.h, mon_e.v);
        check("tok2", {22'd0, d2_word}, {22'd0, 10'b1101010100}, mon_e.h, mon_e.v);
      end
    end
  end

  initial begin
    #95;
    check_reset_state("reset");
    @(posedge hdmi_clk); #5;
    locked = 1'b1; n_edge = 0; running = 1'b1;
    #1 check("oe_before_edge", {31'd0, clk_oe}, 32'd0, -1, -1);
    // Full frame plus a few lines of the next.
    repeat (V_TOT * H_TOT + 3 * H_TOT) @(posedge hdmi_clk);
    #5;
    running = 1'b0; sb.delete();
    locked = 1'b0;
    #1 check_reset_state("midframe_reset");
    repeat (3) @(posedge hdmi_clk);
    #5;
    locked = 1'b1; n_edge = 0; running = 1'b1;
    repeat (6 * H_TOT) @(posedge hdmi_clk);
    #5;
    running = 1'b0;
    check("scoreboard_pops", {31'd0, (n_pops > (V_TOT + 8) * H_TOT)}, 32'd1, -1, -1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
